// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_t;

  localparam logic [3:0] PIX_STORE = 4'd8;

  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage controller: req/ack data-memory access with timeout,
// pipeline stall generation and load-data capture for MEM/WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memtoreg,
  input  logic              memwrite,
  input  logic              memaddrsrc,
  input  logic [3:0]        instr_type,
  input  logic [ADDR_W-1:0] op_a,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] color,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err
);

  localparam int CW = cnt_w(TIMEOUT);

  mem_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              rv_q, rv_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign op = memtoreg | memwrite;

  always_comb begin
    sel_addr      = memaddrsrc ? op_a : alu_result;
    sel_addr[1:0] = 2'b00;
    sel_wdata     = (instr_type == PIX_STORE) ? color : store_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op) begin
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          we_d    = memwrite;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // ack on the last allowed cycle takes priority over timeout
        if (bus_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = bus_rdata;
            rv_d    = 1'b1;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    stall = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE:    stall = op;
        REQ:     stall = 1'b1;
        DONE:    stall = 1'b0;
        default: stall = 1'b0;
      endcase
    end
  end

  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rv_q;
  assign err         = err_q;

endmodule
